// File: rtl/step_loop_sequencer.sv
// Purpose : step/loop play controller; counts tempo ticks within a loop of
//           runtime-selected length, repeats for a programmed loop count
//           (0 = endless) and drives play gating, indices and step strobes.
// Latency : every output is registered and changes one cycle after the
//           start/stop/step_tick that caused it.
// Backpressure: none; step_tick is a 1-cycle strobe that is accepted or
//           dropped (ignored in IDLE / PAUSED), there is no ready handshake.
//
// Optional feature macro: SEQ_PAUSE_EN (pause level input -> PAUSED state).
//
// Ports:
//   clk, nReset          clock (rising edge), async active-low reset
//   start, stop          1-cycle control pulses (stop wins over start)
//   pause                level, honoured only when SEQ_PAUSE_EN is defined
//   step_tick            1-cycle tempo strobe
//   loops, length        run config, sampled only on start
//   play                 run active (and not paused)
//   step_idx, loop_idx   current position
//   step_pulse           new step to sound
//   loop_wrap            a loop finished and another begins
//   done                 finite run completed naturally
module step_loop_sequencer #(
    parameter int MAX_STEPS = 16,
    parameter int LOOP_W    = 8,
    localparam int STEP_W   = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              step_tick,
    input  logic [LOOP_W-1:0] loops,
    input  logic [STEP_W:0]   length,
    output logic              play,
    output logic [STEP_W-1:0] step_idx,
    output logic [LOOP_W-1:0] loop_idx,
    output logic              step_pulse,
    output logic              loop_wrap,
    output logic              done
);

`ifdef SEQ_PAUSE_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;
`else
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // pause has no function in this build
    logic unused_pause;
    assign unused_pause = pause;
`endif

    state_t state, state_nxt;

    // Latched run configuration. The loop is kept as its last index (N-1)
    // and the loop count as its last index (L-1) plus an endless flag, so the
    // per-tick decisions are plain equality compares.
    logic [STEP_W-1:0] last_step, last_step_nxt;
    logic [LOOP_W-1:0] last_loop, last_loop_nxt;
    logic              endless,   endless_nxt;

    logic              play_nxt;
    logic [STEP_W-1:0] step_idx_nxt;
    logic [LOOP_W-1:0] loop_idx_nxt;
    logic              step_pulse_nxt;
    logic              loop_wrap_nxt;
    logic              done_nxt;

    // Length clamp: 0 or anything above MAX_STEPS plays MAX_STEPS steps.
    logic [STEP_W:0] len_clamped;
    logic [STEP_W:0] len_m1;

    always_comb begin
        if (length == '0 || length > (STEP_W+1)'(MAX_STEPS)) begin
            len_clamped = (STEP_W+1)'(MAX_STEPS);
        end else begin
            len_clamped = length;
        end
        // len_clamped is 1..MAX_STEPS, so len_m1 always fits in STEP_W bits
        len_m1 = len_clamped - (STEP_W+1)'(1);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            last_step  <= '0;
            last_loop  <= '0;
            endless    <= 1'b0;
            play       <= 1'b0;
            step_idx   <= '0;
            loop_idx   <= '0;
            step_pulse <= 1'b0;
            loop_wrap  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_step  <= last_step_nxt;
            last_loop  <= last_loop_nxt;
            endless    <= endless_nxt;
            play       <= play_nxt;
            step_idx   <= step_idx_nxt;
            loop_idx   <= loop_idx_nxt;
            step_pulse <= step_pulse_nxt;
            loop_wrap  <= loop_wrap_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_step_nxt  = last_step;
        last_loop_nxt  = last_loop;
        endless_nxt    = endless;
        play_nxt       = play;
        step_idx_nxt   = step_idx;
        loop_idx_nxt   = loop_idx;
        step_pulse_nxt = 1'b0;
        loop_wrap_nxt  = 1'b0;
        done_nxt       = 1'b0;

        if (stop) begin
            // abort from any state; no done strobe
            state_nxt    = S_IDLE;
            play_nxt     = 1'b0;
            step_idx_nxt = '0;
            loop_idx_nxt = '0;
        end else if (start) begin
            // (re)start from any state; a tick in the same cycle is dropped
            state_nxt      = S_RUN;
            last_step_nxt  = len_m1[STEP_W-1:0];
            last_loop_nxt  = loops - LOOP_W'(1);
            endless_nxt    = (loops == '0);
            play_nxt       = 1'b1;
            step_idx_nxt   = '0;
            loop_idx_nxt   = '0;
            step_pulse_nxt = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
`ifdef SEQ_PAUSE_EN
                    if (pause) begin
                        // pause outranks a coincident tick: position is held
                        state_nxt = S_PAUSED;
                        play_nxt  = 1'b0;
                    end else
`endif
                    if (step_tick) begin
                        if (step_idx != last_step) begin
                            step_idx_nxt   = step_idx + STEP_W'(1);
                            step_pulse_nxt = 1'b1;
                        end else if (!endless && loop_idx == last_loop) begin
                            // last step of last loop: finish silently
                            state_nxt    = S_IDLE;
                            play_nxt     = 1'b0;
                            step_idx_nxt = '0;
                            loop_idx_nxt = '0;
                            done_nxt     = 1'b1;
                        end else begin
                            // loop boundary; loop_idx wraps naturally when endless
                            step_idx_nxt   = '0;
                            loop_idx_nxt   = loop_idx + LOOP_W'(1);
                            loop_wrap_nxt  = 1'b1;
                            step_pulse_nxt = 1'b1;
                        end
                    end
                end
`ifdef SEQ_PAUSE_EN
                S_PAUSED: begin
                    // resume without re-sounding the held step
                    if (!pause) begin
                        state_nxt = S_RUN;
                        play_nxt  = 1'b1;
                    end
                end
`endif
                default: begin
                    // IDLE: ticks ignored
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_loop_sequencer.sv
module tb_step_loop_sequencer;

    logic       clk = 1'b0;
    logic       nReset;
    logic       start, stop, pause, step_tick;
    logic [7:0] loops;
    logic [4:0] length;
    logic       play;
    logic [3:0] step_idx;
    logic [7:0] loop_idx;
    logic       step_pulse, loop_wrap, done;

    // small instance for loop-index wrap (LOOP_W=2, MAX_STEPS=4)
    logic       start2, tick2;
    logic [1:0] loops2;
    logic [2:0] length2;
    logic       play2, sp2, lw2, done2;
    logic [1:0] step2, loop2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    step_loop_sequencer dut (
        .clk(clk), .nReset(nReset), .start(start), .stop(stop), .pause(pause),
        .step_tick(step_tick), .loops(loops), .length(length),
        .play(play), .step_idx(step_idx), .loop_idx(loop_idx),
        .step_pulse(step_pulse), .loop_wrap(loop_wrap), .done(done)
    );

    step_loop_sequencer #(.MAX_STEPS(4), .LOOP_W(2)) dut2 (
        .clk(clk), .nReset(nReset), .start(start2), .stop(1'b0), .pause(1'b0),
        .step_tick(tick2), .loops(loops2), .length(length2),
        .play(play2), .step_idx(step2), .loop_idx(loop2),
        .step_pulse(sp2), .loop_wrap(lw2), .done(done2)
    );

    // ---------------- reference model ----------------
    // Position is a single tick count p since start; step/loop follow from
    // division by the loop length N, and the run ends when p reaches L*N.
    bit m_active, m_paused;
    int m_L, m_N = 16, m_p;
    int e_play, e_step, e_loop, e_sp, e_lw, e_done;
    bit model_chk;

    task automatic model_reset();
        m_active = 0; m_paused = 0; m_p = 0; m_N = 16; m_L = 0;
        e_play = 0; e_step = 0; e_loop = 0; e_sp = 0; e_lw = 0; e_done = 0;
    endtask

    task automatic model_step();
        e_sp = 0; e_lw = 0; e_done = 0;
        if (stop) begin
            m_active = 0; m_paused = 0; m_p = 0;
        end else if (start) begin
            m_L = int'(loops);
            m_N = (length == 0 || length > 16) ? 16 : int'(length);
            m_p = 0; m_active = 1; m_paused = 0; e_sp = 1;
        end else if (m_active) begin
`ifdef SEQ_PAUSE_EN
            if (m_paused) begin
                if (!pause) m_paused = 0;
            end else if (pause) begin
                m_paused = 1;
            end else
`endif
            if (step_tick) begin
                m_p++;
                if (m_L != 0 && m_p == m_L * m_N) begin
                    e_done = 1; m_active = 0; m_p = 0;
                end else begin
                    e_sp = 1;
                    if (m_p % m_N == 0) e_lw = 1;
                end
            end
        end
        e_play = (m_active && !m_paused) ? 1 : 0;
        e_step = m_p % m_N;
        e_loop = (m_p / m_N) % 256;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".play"},  int'(play),       e_play);
        check({tag, ".step"},  int'(step_idx),   e_step);
        check({tag, ".loop"},  int'(loop_idx),   e_loop);
        check({tag, ".sp"},    int'(step_pulse), e_sp);
        check({tag, ".wrap"},  int'(loop_wrap),  e_lw);
        check({tag, ".done"},  int'(done),       e_done);
    endtask

    // one clock: model follows the same inputs, outputs sampled 1ns after edge
    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        if (model_chk) check_model(tag);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit start, stop, tick;
        int loops, length;
        int play, step, loop, sp, lw, done;
    } vec_t;

    function automatic vec_t mk(bit s, bit p, bit t, int l, int n,
                                int ep, int es, int el, int esp, int elw, int ed);
        vec_t v;
        v.start = s; v.stop = p; v.tick = t; v.loops = l; v.length = n;
        v.play = ep; v.step = es; v.loop = el; v.sp = esp; v.lw = elw; v.done = ed;
        return v;
    endfunction

    vec_t tbl[24];

    initial begin
        int sp_cnt, done_at;
        int exp_l[6];
        exp_l = '{1, 2, 3, 0, 1, 2};

        // idle ticks
        for (int i = 0; i < 5; i++) tbl[i] = mk(0,0,1, 0,0,  0,0,0,0,0,0);
        // loops=2 length=4, 8 ticks
        tbl[5]  = mk(1,0,0, 2,4,  1,0,0,1,0,0);
        tbl[6]  = mk(0,0,1, 2,4,  1,1,0,1,0,0);
        tbl[7]  = mk(0,0,1, 2,4,  1,2,0,1,0,0);
        tbl[8]  = mk(0,0,1, 2,4,  1,3,0,1,0,0);
        tbl[9]  = mk(0,0,1, 2,4,  1,0,1,1,1,0);
        tbl[10] = mk(0,0,0, 2,4,  1,0,1,0,0,0);
        tbl[11] = mk(0,0,1, 2,4,  1,1,1,1,0,0);
        tbl[12] = mk(0,0,1, 2,4,  1,2,1,1,0,0);
        tbl[13] = mk(0,0,1, 2,4,  1,3,1,1,0,0);
        tbl[14] = mk(0,0,1, 2,4,  0,0,0,0,0,1);
        tbl[15] = mk(0,0,0, 2,4,  0,0,0,0,0,0);
        // restart with coincident tick, then mid-run config change ignored
        tbl[16] = mk(1,0,0, 0,3,  1,0,0,1,0,0);
        tbl[17] = mk(0,0,1, 0,3,  1,1,0,1,0,0);
        tbl[18] = mk(1,0,1, 1,2,  1,0,0,1,0,0);
        tbl[19] = mk(0,0,1, 3,5,  1,1,0,1,0,0);
        tbl[20] = mk(0,0,1, 3,5,  0,0,0,0,0,1);
        // stop beats start
        tbl[21] = mk(1,0,0, 0,2,  1,0,0,1,0,0);
        tbl[22] = mk(1,1,1, 0,2,  0,0,0,0,0,0);
        tbl[23] = mk(0,0,1, 0,2,  0,0,0,0,0,0);

        start = 0; stop = 0; pause = 0; step_tick = 0; loops = 0; length = 0;
        start2 = 0; tick2 = 0; loops2 = 0; length2 = 0;
        model_chk = 0;
        model_reset();

        // reset values
        nReset = 1'b1;
        #1 nReset = 1'b0;
        #1;
        check("rst.play", int'(play), 0);
        check("rst.step", int'(step_idx), 0);
        check("rst.loop", int'(loop_idx), 0);
        check("rst.strobes", int'({step_pulse, loop_wrap, done}), 0);
        @(negedge clk) nReset = 1'b1;

        // table
        for (int i = 0; i < 24; i++) begin
            start = tbl[i].start; stop = tbl[i].stop; step_tick = tbl[i].tick;
            loops = 8'(tbl[i].loops); length = 5'(tbl[i].length);
            cyc("tbl");
            check($sformatf("tbl%0d.play", i), int'(play),       tbl[i].play);
            check($sformatf("tbl%0d.step", i), int'(step_idx),   tbl[i].step);
            check($sformatf("tbl%0d.loop", i), int'(loop_idx),   tbl[i].loop);
            check($sformatf("tbl%0d.sp",   i), int'(step_pulse), tbl[i].sp);
            check($sformatf("tbl%0d.wrap", i), int'(loop_wrap),  tbl[i].lw);
            check($sformatf("tbl%0d.done", i), int'(done),       tbl[i].done);
        end
        start = 0; stop = 0; step_tick = 0;
        model_chk = 1;

        // length clamp: 0 and MAX_STEPS+3 both give 16-step loops
        for (int k = 0; k < 2; k++) begin
            loops = 8'd1; length = (k == 0) ? 5'd0 : 5'd19;
            start = 1; cyc("clamp");
            sp_cnt = int'(step_pulse);
            start = 0; step_tick = 1; done_at = 0;
            for (int i = 1; i <= 20; i++) begin
                cyc("clamp");
                sp_cnt += int'(step_pulse);
                if (done && done_at == 0) done_at = i;
            end
            step_tick = 0;
            check($sformatf("clamp%0d.pulses", k), sp_cnt, 16);
            check($sformatf("clamp%0d.done_at", k), done_at, 16);
        end

        // pause handling
        loops = 8'd1; length = 5'd4; start = 1; cyc("pause");
        start = 0; step_tick = 1; cyc("pause"); cyc("pause");
        check("pause.pre_step", int'(step_idx), 2);
`ifdef SEQ_PAUSE_EN
        step_tick = 0; pause = 1; cyc("pause");
        check("pause.play_low", int'(play), 0);
        step_tick = 1;
        for (int i = 0; i < 3; i++) cyc("pause");
        check("pause.held_step", int'(step_idx), 2);
        check("pause.held_play", int'(play), 0);
        step_tick = 0; pause = 0; cyc("pause");
        check("pause.resume_play", int'(play), 1);
        check("pause.no_repeat", int'(step_pulse), 0);
        step_tick = 1; cyc("pause");
        check("pause.next_step", int'(step_idx), 3);
        check("pause.next_sp", int'(step_pulse), 1);
`else
        pause = 1; cyc("pause");
        check("nopause.step", int'(step_idx), 3);
        check("nopause.play", int'(play), 1);
`endif
        pause = 0; step_tick = 0; stop = 1; cyc("pause"); stop = 0;

        // endless, length 1, LOOP_W=2: loop index wraps 3 -> 0
        loops2 = 2'd0; length2 = 3'd1; start2 = 1; cyc("wrap");
        check("wrap.start_loop", int'(loop2), 0);
        check("wrap.start_sp", int'(sp2), 1);
        start2 = 0; tick2 = 1;
        for (int i = 0; i < 6; i++) begin
            cyc("wrap");
            check($sformatf("wrap%0d.loop", i), int'(loop2), exp_l[i]);
            check($sformatf("wrap%0d.lw", i), int'(lw2), 1);
            check($sformatf("wrap%0d.done", i), int'(done2), 0);
            check($sformatf("wrap%0d.play", i), int'(play2), 1);
        end
        tick2 = 0;

        // async reset mid-run: immediate return to idle, no done
        loops = 8'd0; length = 5'd4; start = 1; cyc("arst");
        start = 0; step_tick = 1; cyc("arst"); cyc("arst"); step_tick = 0;
        nReset = 1'b0;
        #2;
        model_reset();
        check("arst.play", int'(play), 0);
        check("arst.step", int'(step_idx), 0);
        check("arst.done", int'(done), 0);
        #1 nReset = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            stop      = ($urandom_range(99, 0) < 1);
            start     = ($urandom_range(99, 0) < 3);
            step_tick = ($urandom_range(99, 0) < 45);
            if ($urandom_range(99, 0) < 8) pause = ~pause;
            loops     = 8'($urandom_range(3, 0));
            length    = 5'($urandom_range(20, 0));
            cyc("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
